// File: rtl/fetch_unit.sv
// Instruction fetch stage: req/ack fetch into a prefetch FIFO, one instruction per cycle to decode.
// Optional FETCH_PERF_EN adds stall and flush event counters.
module fetch_unit #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] RESET_PC   = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [5:0]  op,
  output logic [5:0]  func
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt
`endif
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

  state_t        state;
  logic [31:0]   fetch_pc;
  logic [31:0]   pc_mem   [FIFO_DEPTH];
  logic [31:0]   data_mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_after;
  logic [31:0]   target_pc;
  logic          push;
  logic          pop;

  assign target_pc   = redirect_pc & ~32'h3;
  assign valid       = (count != '0);
  assign pop         = valid && !stall && !redirect;
  assign push        = (state == REQ) && imem_ack && !redirect;
  assign count_after = count + CW'(push) - CW'(pop);

  assign instr    = valid ? data_mem[rd_ptr] : 32'h0;
  assign instr_pc = valid ? pc_mem[rd_ptr] : 32'h0;
  assign op       = instr[31:26];
  assign func     = instr[5:0];

  // Request FSM; imem_req/imem_addr are registered and only move once the pending request is acked.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      fetch_pc  <= RESET_PC;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
    end else begin
      case (state)
        IDLE: begin
          if (redirect) begin
            fetch_pc <= target_pc;
          end else if (count < DEPTH_C) begin
            state     <= REQ;
            imem_req  <= 1'b1;
            imem_addr <= fetch_pc;
          end
        end
        REQ: begin
          if (redirect) begin
            fetch_pc <= target_pc;
            if (imem_ack) begin
              state    <= IDLE;
              imem_req <= 1'b0;
            end else begin
              state <= DROP;
            end
          end else if (imem_ack) begin
            fetch_pc <= fetch_pc + 32'd4;
            if (count_after < DEPTH_C) begin
              imem_addr <= fetch_pc + 32'd4;
            end else begin
              state    <= IDLE;
              imem_req <= 1'b0;
            end
          end
        end
        DROP: begin
          if (redirect) fetch_pc <= target_pc;
          if (imem_ack) begin
            state    <= IDLE;
            imem_req <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

  // FIFO occupancy and pointers; a redirect empties the FIFO outright.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_after;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]   <= fetch_pc;
      data_mem[wr_ptr] <= imem_rdata;
    end
  end

`ifdef FETCH_PERF_EN
  // A redirect in REQ also discards the in-flight response; one already in DROP was counted earlier.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_stall_cnt <= 32'h0;
      perf_flush_cnt <= 32'h0;
    end else begin
      if (valid && stall) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (redirect)
        perf_flush_cnt <= perf_flush_cnt + 32'(count) + ((state == REQ) ? 32'd1 : 32'd0);
    end
  end
`endif

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch/issue stage. Produces the instruction stream whose op/func fields feed the instruction decoder and controller.
- Requests 32-bit words from instruction memory over a req/ack handshake and buffers them in a small prefetch FIFO.
- Presents one instruction per cycle to decode, with stall and branch/jump redirect (flush) support.

Parameters:
FIFO_DEPTH, 4, prefetch FIFO entries; power of 2, minimum 2
RESET_PC, 32'h00000000, fetch address after reset; bits [1:0] must be 0

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
imem_req  output  1  instruction memory request, held high until imem_ack
imem_addr  output  32  word-aligned fetch address, stable while imem_req high
imem_ack  input  1  one-cycle response strobe; imem_rdata valid in the same cycle
imem_rdata  input  32  fetched instruction word
redirect  input  1  one-cycle pulse from a taken branch, J, JAL or JR
redirect_pc  input  32  new fetch address, sampled when redirect=1
stall  input  1  decode cannot accept this cycle
valid  output  1  instr/op/func/instr_pc hold a real instruction
instr  output  32  instruction at FIFO head; 32'h0 (NOP) when valid=0
instr_pc  output  32  address of instr; 0 when valid=0
op  output  6  instr[31:26]; 0 when valid=0
func  output  6  instr[5:0]; 0 when valid=0

Behaviour:
- Asynchronous reset:
  - fetch_pc=RESET_PC, FIFO empty, state=IDLE.
  - imem_req=0, imem_addr=RESET_PC, valid=0, instr/instr_pc/op/func=0.
- Reset mid-request aborts it; a late imem_ack after reset release is ignored (state=IDLE).
- FSM states:
  - IDLE→REQ when count+pending < FIFO_DEPTH and no redirect this cycle.
  - REQ: imem_req=1, imem_addr=fetch_pc.
    - On imem_ack: push {fetch_pc, imem_rdata} and set fetch_pc+=4 (32-bit wrap, 32'hFFFFFFFC→0).
    - Then go to REQ again if space remains after the push and pop, else IDLE.
  - REQ with redirect and no ack in the same cycle → DROP. DROP keeps imem_req=1 at the old address until imem_ack, discards that data, then goes to IDLE.
  - REQ with redirect and ack in the same cycle: the data is discarded, no push, → IDLE.
- At most one outstanding request. imem_addr and imem_req must not change while a request is unacked.
- Redirect handling:
  - Flushes every FIFO entry in the same cycle; valid=0 the next cycle.
  - fetch_pc=redirect_pc with [1:0] forced to 0.
  - Redirect has priority over a pop in the same cycle.
- Issue (combinational from FIFO head): valid = !empty. Pop when valid && !stall && !redirect.
- Push and pop in the same cycle: count unchanged, allowed when full.
- Push when full never occurs, because of the request gating.
- Minimum latency: imem_ack in cycle N into an empty FIFO → valid=1 in cycle N+1.
- Sustained throughput is one instruction per cycle with a zero-wait memory (imem_ack the cycle after imem_req rises).
- Output while stalled: instr/op/func/instr_pc hold steady.
- Bubble encoding: instr=0, which is SLL $0,$0,0 and decodes as a harmless NOP.

Optional Feature:
- Macro: FETCH_PERF_EN.
- When defined, adds two output ports:
  - perf_stall_cnt (32): increments each cycle valid && stall.
  - perf_flush_cnt (32): increments by the number of entries discarded per redirect, including one for a dropped in-flight response.
- Both counters reset to 0 on reset_n low and wrap at 2^32.
- When undefined, the ports and logic are absent; all other behaviour is identical.

Test Plan:
1. Reset release, zero-wait memory returning imem_addr as data → imem_addr 0,4,8,C…; valid rises the cycle after the first ack; instr_pc=0,4,8 on consecutive cycles; op/func match data.
2. stall=1 for 6 cycles at FIFO_DEPTH=4 → exactly 4 words buffered, imem_req drops; outputs hold instr_pc=0x10; after release the sequence continues 0x10,0x14… with no gap or duplicate.
3. redirect with redirect_pc=0x200 while a request to 0x18 is unacked and ack arrives 3 cycles later → that data is discarded; the next imem_addr is 0x200; valid=0 until the 0x200 word returns.
4. redirect with redirect_pc=0x403 in the same cycle as imem_ack and pop → no push, FIFO empty, next fetch at 0x400.
5. RESET_PC=32'hFFFFFFF8 → fetches 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
6. reset_n pulsed low mid-REQ, then a stale imem_ack → ignored; the fetch restarts at RESET_PC. With FETCH_PERF_EN, the counters read 0 after reset.
